// File: rtl/cen_frac_gen.sv
// cen_frac_gen
//   Fractional clock-enable generator. Each channel runs a num/den phase
//   accumulator and emits a registered one-cycle cen pulse each time the
//   accumulator crosses den, so the average pulse rate is exactly num/den of
//   clk_sys with no drift.
//
// Optional feature macro: CEN_TURBO_EN
//   When defined, turbo high makes channel 0 use min(2*num, den) as its
//   increment. When undefined, turbo is ignored and no turbo logic exists.
//
// Ports
//   clk_sys  in   sole clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   pause    in   hold all accumulators, force cen low
//   sync     in   clear every accumulator (phase alignment)
//   cfg_wr   in   load cfg_num/cfg_den into channel cfg_ch, clear its acc
//   cfg_ch   in   target channel; indices >= CHANNELS are ignored
//   cfg_num  in   new numerator
//   cfg_den  in   new denominator
//   turbo    in   channel 0 speed-up request (CEN_TURBO_EN only)
//   cen      out  registered enable pulses, one bit per channel
module cen_frac_gen #(
  parameter int CHANNELS  = 2,
  parameter int ACC_W     = 10,
  parameter int RESET_DEN = 4,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                pause,
  input  logic                sync,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  input  logic                turbo,
  output logic [CHANNELS-1:0] cen
);

  // Reset release is retimed through one flop: the first edge after reset_n
  // rises only arms run_q, accumulation starts on the second edge.
  logic run_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

`ifndef CEN_TURBO_EN
  logic unused_turbo;
  assign unused_turbo = turbo;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [ACC_W-1:0] num_q;
    logic [ACC_W-1:0] den_q;
    logic [ACC_W-1:0] acc_q;
    logic             cen_q;
    logic [ACC_W:0]   num_eff;
    logic [ACC_W:0]   den_x;
    logic [ACC_W:0]   sum;
    logic             hit;

    assign hit   = cfg_wr && (cfg_ch == CH_W'(i));
    assign den_x = {1'b0, den_q};
    assign sum   = {1'b0, acc_q} + num_eff;

`ifdef CEN_TURBO_EN
    if (i == 0) begin : g_turbo
      logic [ACC_W:0] dbl;
      assign dbl     = {num_q, 1'b0};
      // Clamp at den: beyond that the channel is already saturated.
      assign num_eff = !turbo       ? {1'b0, num_q} :
                       (dbl > den_x) ? den_x : dbl;
    end else begin : g_plain
      assign num_eff = {1'b0, num_q};
    end
`else
    assign num_eff = {1'b0, num_q};
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        num_q <= ACC_W'(1);
        den_q <= ACC_W'(RESET_DEN);
        acc_q <= '0;
        cen_q <= 1'b0;
      end else begin
        if (hit) begin
          num_q <= cfg_num;
          den_q <= cfg_den;
        end

        if (!run_q) begin
          cen_q <= 1'b0;
        end else if (sync || hit) begin
          acc_q <= '0;
          cen_q <= 1'b0;
        end else if (pause) begin
          cen_q <= 1'b0;
        end else if (den_q == '0) begin
          acc_q <= '0;
          cen_q <= 1'b0;
        end else if (num_eff >= den_x) begin
          // Saturated: pulse every cycle, keep acc pinned at 0.
          acc_q <= '0;
          cen_q <= 1'b1;
        end else if (sum >= den_x) begin
          acc_q <= ACC_W'(sum - den_x);
          cen_q <= 1'b1;
        end else begin
          acc_q <= ACC_W'(sum);
          cen_q <= 1'b0;
        end
      end
    end

    assign cen[i] = cen_q;
  end

endmodule

// File: tb/tb_cen_frac_gen.sv
// Self-checking bench for cen_frac_gen (3 channels so an out-of-range
// cfg_ch exists). A reference model predicts cen for every edge; the
// prediction is queued when inputs are driven and popped after the edge.
module tb_cen_frac_gen;

  localparam int CH = 3;
  localparam int AW = 10;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          pause, sync, cfg_wr, turbo;
  logic [1:0]    cfg_ch;
  logic [AW-1:0] cfg_num, cfg_den;
  logic [CH-1:0] cen;

  cen_frac_gen #(.CHANNELS(CH), .ACC_W(AW), .RESET_DEN(4)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .pause   (pause),
    .sync    (sync),
    .cfg_wr  (cfg_wr),
    .cfg_ch  (cfg_ch),
    .cfg_num (cfg_num),
    .cfg_den (cfg_den),
    .turbo   (turbo),
    .cen     (cen)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  int m_num [CH];
  int m_den [CH];
  int m_acc [CH];
  bit m_run;

  logic [CH-1:0] exp_q [$];
  logic [CH-1:0] last_cen;
  int            pc [CH];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_num[c] = 1;
      m_den[c] = 4;
      m_acc[c] = 0;
    end
    m_run = 1'b0;
  endtask

  // Expected cen after the coming edge, given current inputs and state.
  task automatic model_step(output logic [CH-1:0] e);
    int ne, s;
    bit hit;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      hit = cfg_wr && (int'(cfg_ch) == c);
      ne  = m_num[c];
`ifdef CEN_TURBO_EN
      if (c == 0 && turbo) ne = (2 * m_num[c] > m_den[c]) ? m_den[c] : 2 * m_num[c];
`endif
      if (!m_run) begin
        e[c] = 1'b0;
      end else if (sync || hit) begin
        m_acc[c] = 0;
      end else if (pause) begin
        e[c] = 1'b0;
      end else if (m_den[c] == 0) begin
        m_acc[c] = 0;
      end else if (ne >= m_den[c]) begin
        m_acc[c] = 0;
        e[c] = 1'b1;
      end else begin
        s = m_acc[c] + ne;
        if (s >= m_den[c]) begin
          m_acc[c] = s - m_den[c];
          e[c] = 1'b1;
        end else begin
          m_acc[c] = s;
        end
      end
      if (hit) begin
        m_num[c] = int'(cfg_num);
        m_den[c] = int'(cfg_den);
      end
    end
    m_run = 1'b1;
  endtask

  task automatic tick();
    logic [CH-1:0] e;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk_sys);
    #1;
    e = exp_q.pop_front();
    check_eq("cen", 32'(cen), 32'(e));
    last_cen = cen;
    for (int c = 0; c < CH; c++) pc[c] += int'(cen[c]);
  endtask

  task automatic clr_counts();
    for (int c = 0; c < CH; c++) pc[c] = 0;
  endtask

  task automatic cfg(input int ch, input int num, input int den);
    cfg_ch  = 2'(ch);
    cfg_num = AW'(num);
    cfg_den = AW'(den);
    cfg_wr  = 1'b1;
    tick();
    cfg_wr  = 1'b0;
  endtask

  logic [7:0] pat;
  int         first_idx;

  initial begin
    reset_n = 1'b0;
    pause = 0; sync = 0; cfg_wr = 0; turbo = 0;
    cfg_ch = '0; cfg_num = '0; cfg_den = '0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("reset_cen", 32'(cen), 32'd0);

    // Release away from the edge; first edge only arms the channels.
    @(negedge clk_sys);
    reset_n = 1'b1;
    tick();
    check_eq("first_edge_idle", 32'(last_cen), 32'd0);

    // Defaults 1/4: every 4th cycle, aligned, 6 pulses in 24 cycles.
    clr_counts();
    for (int k = 0; k < 24; k++) begin
      tick();
      if (k % 4 == 3) check_eq("default_aligned", 32'(last_cen), 32'b111);
    end
    check_eq("default_cnt0", pc[0], 6);
    check_eq("default_cnt1", pc[1], 6);
    check_eq("default_cnt2", pc[2], 6);

    // 3/8: pulses on cycles 3, 6, 8 of each window, repeating.
    cfg(0, 3, 8);
    for (int w = 0; w < 2; w++) begin
      pat = '0;
      for (int k = 0; k < 8; k++) begin
        tick();
        pat[k] = last_cen[0];
      end
      check_eq("frac_3_8_pattern", 32'(pat), 32'hA4);
    end

    // Pause at acc=2 on ch1: silent while paused, pulse 2 cycles after release.
    cfg(1, 1, 4);
    tick(); tick();
    pause = 1'b1;
    clr_counts();
    repeat (5) tick();
    check_eq("pause_silent", pc[1], 0);
    pause = 1'b0;
    first_idx = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (first_idx < 0 && last_cen[1]) first_idx = k;
    end
    check_eq("pause_resume_idx", 32'(first_idx), 32'd2);

    // Sync aligns ch0 (1/4) and ch1 (1/2): both high on 4th cycle after.
    cfg(0, 1, 4);
    cfg(1, 1, 2);
    repeat (7) tick();
    sync = 1'b1;
    tick();
    check_eq("sync_clears_cen", 32'(last_cen), 32'd0);
    sync = 1'b0;
    repeat (2) tick();
    tick();
    check_eq("sync_cycle3", 32'(last_cen[1:0]), 32'b00);
    tick();
    check_eq("sync_cycle4", 32'(last_cen[1:0]), 32'b11);

    // Out-of-range channel write must touch nothing.
    cfg(3, 0, 0);
    clr_counts();
    repeat (8) tick();
    check_eq("oob_ch0_cnt", pc[0], 2);
    check_eq("oob_ch1_cnt", pc[1], 4);

    // Boundary ratios on ch2.
    cfg(2, 0, 5);
    clr_counts();
    repeat (100) tick();
    check_eq("num0_cnt", pc[2], 0);
    cfg(2, 5, 5);
    clr_counts();
    repeat (10) tick();
    check_eq("num_eq_den_cnt", pc[2], 10);
    cfg(2, 7, 5);
    clr_counts();
    repeat (10) tick();
    check_eq("num_gt_den_cnt", pc[2], 10);
    cfg(2, 3, 0);
    clr_counts();
    repeat (10) tick();
    check_eq("den0_cnt", pc[2], 0);

    // Turbo request on ch0 at 1/4.
    cfg(0, 1, 4);
    turbo = 1'b1;
    clr_counts();
    repeat (8) tick();
`ifdef CEN_TURBO_EN
    check_eq("turbo_cnt", pc[0], 4);
`else
    check_eq("turbo_cnt", pc[0], 2);
`endif
    turbo = 1'b0;

    // Randomised mix: pause, sync, cfg (incl. collisions), turbo.
    for (int k = 0; k < 400; k++) begin
      pause   = ($urandom_range(0, 7) == 0);
      sync    = ($urandom_range(0, 15) == 0);
      cfg_wr  = ($urandom_range(0, 5) == 0);
      cfg_ch  = 2'($urandom_range(0, 3));
      cfg_num = AW'($urandom_range(0, 7));
      cfg_den = AW'($urandom_range(0, 7));
      turbo   = $urandom_range(0, 1) == 1;
      tick();
    end
    pause = 0; sync = 0; cfg_wr = 0; turbo = 0;

    // Reset in the middle of a steady-high pulse train drops cen at once.
    cfg(0, 5, 5);
    tick(); tick();
    check_eq("pre_reset_high", 32'(last_cen[0]), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset_cen", 32'(cen), 32'd0);
    model_reset();
    @(negedge clk_sys);
    reset_n = 1'b1;
    tick();
    clr_counts();
    repeat (8) tick();
    check_eq("post_reset_cnt0", pc[0], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
